// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: single-outstanding fetch with fixed read latency,
// fault classification, flush, and a program-load write port.
module instr_fetch_mem #(
    parameter int                DATA_W        = 32,
    parameter int                DEPTH         = 1024,
    parameter int                ADDR_W        = 32,
    parameter int                RD_LAT        = 1,
    parameter logic [DATA_W-1:0] DEFAULT_INSTR = 32'hDEADBEEF,
    parameter string             INIT_FILE     = ""
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_W-1:0]        resp_instr,
    output logic [1:0]               resp_fault,
    input  logic                     flush,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [DATA_W-1:0]        load_data,
    output logic [15:0]              fault_count
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [1:0] LAT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    // Power-up image: default word everywhere.
    function automatic mem_t load_image();
        mem_t img;
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = DEFAULT_INSTR;
        end
        return img;
    endfunction

    mem_t mem = load_image();

    state_t            state_reg;
    logic [1:0]        lat_cnt_reg;
    logic [ADDR_W-1:0] word_idx;
    logic              misaligned;
    logic              out_of_range;
    logic [1:0]        fault_code;
    logic [DATA_W-1:0] fetch_word;
    logic              accept;

    assign word_idx     = req_addr >> 2;
    assign misaligned   = |req_addr[1:0];
    assign out_of_range = word_idx >= ADDR_W'(DEPTH);
    assign fault_code   = misaligned   ? 2'b10 :
                          out_of_range ? 2'b01 : 2'b00;
    assign fetch_word   = mem[word_idx[IDX_W-1:0]];

    assign req_ready = !rst && !flush &&
                       ((state_reg == IDLE) || ((state_reg == RESP) && resp_ready));
    assign accept    = req_valid && req_ready;

    // load_addr is exactly IDX_W bits wide, so every value is a legal word index.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            lat_cnt_reg <= 2'd0;
            resp_valid  <= 1'b0;
            resp_instr  <= '0;
            resp_fault  <= 2'b00;
            fault_count <= 16'd0;
        end else if (flush) begin
            state_reg  <= IDLE;
            resp_valid <= 1'b0;
        end else if (accept) begin
            // mem is sampled before this edge's load lands: read-before-write.
            resp_instr <= (fault_code != 2'b00) ? DEFAULT_INSTR : fetch_word;
            resp_fault <= fault_code;
            if ((fault_code != 2'b00) && (fault_count != 16'hFFFF)) begin
                fault_count <= fault_count + 16'd1;
            end
            if (RD_LAT == 1) begin
                state_reg  <= RESP;
                resp_valid <= 1'b1;
            end else begin
                state_reg   <= WAIT;
                lat_cnt_reg <= LAT_INIT;
                resp_valid  <= 1'b0;
            end
        end else begin
            case (state_reg)
                WAIT: begin
                    if (lat_cnt_reg == 2'd0) begin
                        state_reg  <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 2'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_reg  <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Three DUT lanes (read latency 1, 2, 4) driven one at a time and checked
// against a transaction-level model: word store, fault rules and latency.
module tb_instr_fetch_mem;

    localparam int NL    = 3;
    localparam int DEPTH = 1024;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 4;
    endfunction

    logic        clk = 1'b0;
    logic        rst         [NL];
    logic        req_valid   [NL];
    logic        req_ready   [NL];
    logic [31:0] req_addr    [NL];
    logic        resp_valid  [NL];
    logic        resp_ready  [NL];
    logic [31:0] resp_instr  [NL];
    logic [1:0]  resp_fault  [NL];
    logic        flush       [NL];
    logic        load_en     [NL];
    logic [9:0]  load_addr   [NL];
    logic [31:0] load_data   [NL];
    logic [15:0] fault_count [NL];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_dut
            instr_fetch_mem #(.RD_LAT(lat_of(gi))) u_dut (
                .clk(clk), .rst(rst[gi]),
                .req_valid(req_valid[gi]), .req_ready(req_ready[gi]), .req_addr(req_addr[gi]),
                .resp_valid(resp_valid[gi]), .resp_ready(resp_ready[gi]),
                .resp_instr(resp_instr[gi]), .resp_fault(resp_fault[gi]),
                .flush(flush[gi]), .load_en(load_en[gi]), .load_addr(load_addr[gi]),
                .load_data(load_data[gi]), .fault_count(fault_count[gi])
            );
        end
    endgenerate

    logic [31:0] ref_mem   [NL][DEPTH];
    int          ref_fc    [NL];
    logic [31:0] exp_instr [NL];
    logic [1:0]  exp_fault [NL];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input int ln, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s lane %0d got %h expected %h", tag, ln, got, exp);
        end
    endtask

    task automatic load_word(input int ln, input int a, input logic [31:0] d);
        load_en[ln] = 1'b1; load_addr[ln] = 10'(a); load_data[ln] = d;
        @(posedge clk); #1;
        load_en[ln] = 1'b0;
        ref_mem[ln][a] = d;
    endtask

    // Present a request (optionally with a load on the same edge) and expect acceptance.
    task automatic issue(input int ln, input logic [31:0] addr, input bit ld,
                         input int la, input logic [31:0] ld_d);
        req_valid[ln] = 1'b1; req_addr[ln] = addr;
        if (ld) begin
            load_en[ln] = 1'b1; load_addr[ln] = 10'(la); load_data[ln] = ld_d;
        end
        #1;
        chk("req_ready_accept", ln, 32'(req_ready[ln]), 32'd1);
        if (addr % 4 != 0)            exp_fault[ln] = 2'b10;
        else if (addr / 4 >= DEPTH)   exp_fault[ln] = 2'b01;
        else                          exp_fault[ln] = 2'b00;
        exp_instr[ln] = (exp_fault[ln] != 2'b00) ? 32'hDEADBEEF : ref_mem[ln][addr / 4];
        if (exp_fault[ln] != 2'b00 && ref_fc[ln] < 65535) ref_fc[ln]++;
        $display("lane %0d fetch addr %h load %0d -> instr %h fault %0d",
                 ln, addr, ld, exp_instr[ln], exp_fault[ln]);
        @(posedge clk); #1;
        req_valid[ln] = 1'b0; load_en[ln] = 1'b0; resp_ready[ln] = 1'b0;
        if (ld) ref_mem[ln][la] = ld_d;
    endtask

    // Follow the accepted fetch through its latency, then hold it for extra cycles.
    task automatic await_resp(input int ln, input int hold);
        int lat = lat_of(ln);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c < lat) begin
                chk("valid_early", ln, 32'(resp_valid[ln]), 32'd0);
                chk("ready_in_wait", ln, 32'(req_ready[ln]), 32'd0);
            end else begin
                chk("valid_on_time", ln, 32'(resp_valid[ln]), 32'd1);
                chk("instr", ln, resp_instr[ln], exp_instr[ln]);
                chk("fault", ln, 32'(resp_fault[ln]), 32'(exp_fault[ln]));
                chk("fault_count", ln, 32'(fault_count[ln]), 32'(ref_fc[ln]));
                chk("ready_resp_stall", ln, 32'(req_ready[ln]), 32'd0);
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", ln, 32'(resp_valid[ln]), 32'd1);
            chk("hold_instr", ln, resp_instr[ln], exp_instr[ln]);
            chk("hold_ready", ln, 32'(req_ready[ln]), 32'd0);
        end
    endtask

    task automatic release_resp(input int ln);
        resp_ready[ln] = 1'b1;
        #1;
        chk("ready_on_consume", ln, 32'(req_ready[ln]), 32'd1);
        @(posedge clk); #1;
        resp_ready[ln] = 1'b0;
        @(negedge clk);
        chk("valid_dropped", ln, 32'(resp_valid[ln]), 32'd0);
        chk("instr_held", ln, resp_instr[ln], exp_instr[ln]);
        chk("fault_held", ln, 32'(resp_fault[ln]), 32'(exp_fault[ln]));
        chk("ready_idle", ln, 32'(req_ready[ln]), 32'd1);
    endtask

    task automatic random_addr(output logic [31:0] addr);
        int kind = $urandom_range(0, 9);
        int w    = $urandom_range(0, 15);
        case (kind)
            6:       addr = 32'(w * 4 + $urandom_range(1, 3));
            7:       addr = {$urandom} & 32'hFFFF_FFFC | 32'h0000_1000;
            8:       addr = 32'h0000_0FFC;
            9:       addr = 32'h0000_1000;
            default: addr = 32'(w * 4);
        endcase
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog lane 0 got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        for (int l = 0; l < NL; l++) begin
            rst[l] = 1'b1; req_valid[l] = 1'b0; req_addr[l] = '0; resp_ready[l] = 1'b0;
            flush[l] = 1'b0; load_en[l] = 1'b0; load_addr[l] = '0; load_data[l] = '0;
            ref_fc[l] = 0; exp_instr[l] = '0; exp_fault[l] = '0;
            for (int i = 0; i < DEPTH; i++) ref_mem[l][i] = 32'hDEADBEEF;
        end
        #2;
        for (int l = 0; l < NL; l++) begin
            chk("rst_valid", l, 32'(resp_valid[l]), 32'd0);
            chk("rst_ready", l, 32'(req_ready[l]), 32'd0);
            chk("rst_instr", l, resp_instr[l], 32'd0);
            chk("rst_fault", l, 32'(resp_fault[l]), 32'd0);
            chk("rst_fault_count", l, 32'(fault_count[l]), 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int l = 0; l < NL; l++) rst[l] = 1'b0;

        for (int l = 0; l < NL; l++) begin
            load_word(l, 2, 32'h01094020);
            for (int i = 4; i < 8; i++) load_word(l, i, $urandom);
        end

        // Latency 2 aligned fetch of word 2.
        issue(1, 32'h8, 0, 0, 0); await_resp(1, 0); release_resp(1);

        // Misaligned, out-of-range, and last in-range word on latency 1.
        issue(0, 32'h6, 0, 0, 0);      await_resp(0, 0); release_resp(0);
        issue(0, 32'h1000, 0, 0, 0);   await_resp(0, 0); release_resp(0);
        chk("fault_count_two", 0, 32'(fault_count[0]), 32'd2);
        issue(0, 32'hFFC, 0, 0, 0);    await_resp(0, 0); release_resp(0);

        // Stall in RESP, then back-to-back; then read-before-write on a same-edge load.
        for (int l = 0; l < NL; l++) begin
            issue(l, 32'h10, 0, 0, 0); await_resp(l, 5);
            resp_ready[l] = 1'b1;
            issue(l, 32'h14, 0, 0, 0); await_resp(l, 0); release_resp(l);
            issue(l, 32'hC, 1, 3, 32'hCAFE0001); await_resp(l, 0); release_resp(l);
            issue(l, 32'hC, 0, 0, 0);            await_resp(l, 0); release_resp(l);
        end

        // Flush during WAIT on latency 4; the request shown with flush is refused.
        issue(2, 32'h8, 0, 0, 0);
        @(negedge clk);
        flush[2] = 1'b1; req_valid[2] = 1'b1; req_addr[2] = 32'h4;
        #1;
        chk("ready_during_flush", 2, 32'(req_ready[2]), 32'd0);
        @(posedge clk); #1;
        flush[2] = 1'b0; req_valid[2] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("no_valid_after_flush", 2, 32'(resp_valid[2]), 32'd0);
            chk("idle_after_flush", 2, 32'(req_ready[2]), 32'd1);
        end

        // Flush during RESP on latency 1.
        issue(0, 32'h8, 0, 0, 0); await_resp(0, 1);
        flush[0] = 1'b1;
        @(posedge clk); #1;
        flush[0] = 1'b0;
        @(negedge clk);
        chk("resp_flushed", 0, 32'(resp_valid[0]), 32'd0);
        chk("idle_after_resp_flush", 0, 32'(req_ready[0]), 32'd1);

        // Randomised traffic with same-edge loads and optional back-to-back handoff.
        for (int l = 0; l < NL; l++) begin
            bit in_resp = 0;
            for (int t = 0; t < 40; t++) begin
                bit ld = ($urandom_range(0, 9) < 3);
                int la = $urandom_range(0, 15);
                if (in_resp) begin
                    if ($urandom_range(0, 1) == 1) resp_ready[l] = 1'b1;
                    else release_resp(l);
                end
                random_addr(a);
                issue(l, a, ld, la, $urandom);
                await_resp(l, $urandom_range(0, 3));
                in_resp = 1;
            end
            release_resp(l);
        end

        // Asynchronous reset mid-RESP; memory survives and the next fetch is accepted.
        issue(1, 32'h6, 0, 0, 0); await_resp(1, 1);
        rst[1] = 1'b1;
        #1;
        chk("arst_valid", 1, 32'(resp_valid[1]), 32'd0);
        chk("arst_instr", 1, resp_instr[1], 32'd0);
        chk("arst_fault", 1, 32'(resp_fault[1]), 32'd0);
        chk("arst_fault_count", 1, 32'(fault_count[1]), 32'd0);
        chk("arst_ready", 1, 32'(req_ready[1]), 32'd0);
        ref_fc[1] = 0;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        issue(1, 32'h8, 0, 0, 0); await_resp(1, 0); release_resp(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
